// File: rtl/tof_est_pkg.sv
// Shared definitions for the time-of-flight phase estimator:
// FSM state encoding, default-width measurement limits and a signed
// saturation helper used by the estimator datapath.
package tof_est_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAG    = 2'd1,
        LEAD   = 2'd2,
        UPDATE = 2'd3
    } tof_state_e;

    // Limits for the default 8-bit build; the measurement range is symmetric.
    localparam int unsigned CNT_W_DEF = 8;
    localparam int          TOF_MAX   = (2 ** (CNT_W_DEF - 1)) - 1;
    localparam int          TOF_MIN   = -TOF_MAX;

    // Clamp a signed value into the two's-complement range of 'width' bits.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                                 input int unsigned        width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/tof_est_update.sv
// Combinational estimator step: Y_next = sat(Y + floor((tof - Y) * W / 2^W_W)).
// W is an unsigned fraction; the product is kept wide enough to be exact.
module tof_est_update
    import tof_est_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned W_W   = 4
) (
    input  logic [CNT_W-1:0] tof_i,
    input  logic [CNT_W-1:0] y_i,
    input  logic [W_W-1:0]   w_i,
    output logic [CNT_W-1:0] y_next_o
);

    localparam int unsigned PW = CNT_W + W_W + 2;

    logic signed [CNT_W:0] diff;
    logic signed [PW-1:0]  diff_x;
    logic signed [PW-1:0]  w_x;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  quot;
    logic signed [PW-1:0]  y_x;
    logic signed [PW-1:0]  sum;
    logic signed [31:0]    sum32;

    // Error term, weighted product, floor shift and saturated accumulate.
    always_comb begin
        diff     = signed'({tof_i[CNT_W-1], tof_i}) - signed'({y_i[CNT_W-1], y_i});
        diff_x   = {{(PW-CNT_W-1){diff[CNT_W]}}, diff};
        w_x      = {{(PW-W_W){1'b0}}, w_i};
        prod     = diff_x * w_x;
        quot     = prod >>> W_W;
        y_x      = {{(PW-CNT_W){y_i[CNT_W-1]}}, y_i};
        sum      = quot + y_x;
        sum32    = {{(32-PW){sum[PW-1]}}, sum};
        y_next_o = CNT_W'(sat_s(sum32, CNT_W));
    end

endmodule

// File: rtl/tof_phase_estimator.sv
// Time-of-flight phase estimator: measures the signed cycle offset between
// the rising edges of X1 and X2 and tracks it with a first-order adaptive
// estimator Y += W*(tof - Y).
// Build option: define DUAL_EDGE_EN to also measure falling-edge pairs.
module tof_phase_estimator
    import tof_est_pkg::*;
#(
    parameter int unsigned    CNT_W       = 8,
    parameter int unsigned    W_W         = 4,
    parameter logic [W_W-1:0] W_RST       = W_W'(8),
    parameter int unsigned    SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             X1,
    input  logic             X2,
    input  logic             l_r,
    input  logic [W_W-1:0]   W_ext,
    output logic [CNT_W-1:0] tof_count,
    output logic [CNT_W-1:0] Y_output,
    output logic             data_ready
);

    localparam logic [CNT_W-2:0] CNT_ONE = (CNT_W-1)'(1);

    logic [SYNC_STAGES-1:0] x1_sync_q;
    logic [SYNC_STAGES-1:0] x2_sync_q;
    logic                   x1_prev_q;
    logic                   x2_prev_q;
    logic                   x1_s;
    logic                   x2_s;
    logic                   x1_rise;
    logic                   x2_rise;
    logic                   x1_fall;
    logic                   x2_fall;

    logic                   start_x1;
    logic                   start_x2;
    logic                   lag_close;
    logic                   lag_abort;
    logic                   lead_close;
    logic                   lead_abort;

    tof_state_e             state_q, state_d;
    logic [CNT_W-2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       tof_q, tof_d;
    logic [CNT_W-1:0]       y_q, y_d;
    logic                   dr_q, dr_d;
    logic [W_W-1:0]         w_q, w_d;
    logic [CNT_W-1:0]       y_next;

    // Metastability synchronisers plus one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            x1_sync_q <= '0;
            x2_sync_q <= '0;
            x1_prev_q <= 1'b0;
            x2_prev_q <= 1'b0;
        end else begin
            x1_sync_q <= {x1_sync_q[SYNC_STAGES-2:0], X1};
            x2_sync_q <= {x2_sync_q[SYNC_STAGES-2:0], X2};
            x1_prev_q <= x1_sync_q[SYNC_STAGES-1];
            x2_prev_q <= x2_sync_q[SYNC_STAGES-1];
        end
    end

    assign x1_s    = x1_sync_q[SYNC_STAGES-1];
    assign x2_s    = x2_sync_q[SYNC_STAGES-1];
    assign x1_rise = x1_s & ~x1_prev_q;
    assign x2_rise = x2_s & ~x2_prev_q;
    assign x1_fall = ~x1_s & x1_prev_q;
    assign x2_fall = ~x2_s & x2_prev_q;

`ifdef DUAL_EDGE_EN
    // Polarity of the measurement in progress: 1 when it opened on falling edges.
    logic pol_q, pol_d;
    logic use_fall;

    // Select opening/closing/abort edges by the polarity of the pair.
    always_comb begin
        use_fall   = ~(x1_rise | x2_rise) & (x1_fall | x2_fall);
        pol_d      = (state_q == IDLE) ? use_fall : pol_q;
        start_x1   = use_fall ? x1_fall : x1_rise;
        start_x2   = use_fall ? x2_fall : x2_rise;
        lag_close  = pol_q ? x2_fall : x2_rise;
        lag_abort  = pol_q ? x1_rise : x1_fall;
        lead_close = pol_q ? x1_fall : x1_rise;
        lead_abort = pol_q ? x2_rise : x2_fall;
    end

    // Measurement polarity register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end
`else
    // Rising edges open and close a measurement; a fall of the leader aborts.
    always_comb begin
        start_x1   = x1_rise;
        start_x2   = x2_rise;
        lag_close  = x2_rise;
        lag_abort  = x1_fall;
        lead_close = x1_rise;
        lead_abort = x2_fall;
    end
`endif

    // Measurement FSM: count cycles between the leading and lagging edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tof_d   = tof_q;
        unique case (state_q)
            IDLE: begin
                if (start_x1 && start_x2) begin
                    state_d = UPDATE;
                    tof_d   = '0;
                end else if (start_x1) begin
                    state_d = LAG;
                    cnt_d   = CNT_ONE;
                end else if (start_x2) begin
                    state_d = LEAD;
                    cnt_d   = CNT_ONE;
                end
            end
            LAG: begin
                if (lag_close) begin
                    state_d = UPDATE;
                    tof_d   = {1'b0, cnt_q};
                    cnt_d   = '0;
                end else if (lag_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LEAD: begin
                if (lead_close) begin
                    state_d = UPDATE;
                    tof_d   = '0 - {1'b0, cnt_q};
                    cnt_d   = '0;
                end else if (lead_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    tof_est_update #(
        .CNT_W (CNT_W),
        .W_W   (W_W)
    ) u_update (
        .tof_i    (tof_q),
        .y_i      (y_q),
        .w_i      (w_q),
        .y_next_o (y_next)
    );

    // Estimator output, ready strobe and weight load; UPDATE reads the old W.
    always_comb begin
        w_d  = l_r ? W_ext : w_q;
        y_d  = (state_q == UPDATE) ? y_next : y_q;
        dr_d = (state_q == UPDATE);
    end

    // State, counter, measurement and estimator registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tof_q   <= '0;
            y_q     <= '0;
            dr_q    <= 1'b0;
            w_q     <= W_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tof_q   <= tof_d;
            y_q     <= y_d;
            dr_q    <= dr_d;
            w_q     <= w_d;
        end
    end

    assign tof_count  = tof_q;
    assign Y_output   = y_q;
    assign data_ready = dr_q;

endmodule
